// File: rtl/spi_row_packer.sv
// spi_row_packer
// Packs WWIDTH-bit words strobed in from the QSPI interface, MSB-first,
// into DWIDTH-bit rows and pushes each completed row into a sync_fifo
// write port. A completed row waits in a hold register while the next
// row assembles. A row that completes while the hold register is occupied
// and the FIFO is full is dropped, and the sticky ovf flag is set.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   push_en     one-cycle strobe, wdata_spi valid
//   wdata_spi   word from QSPI
//   sof         start of frame, discards the partially assembled row
//   clr_ovf     clears the sticky overflow flag
//   full_fifo   FIFO full flag
//   wr_en_fifo  FIFO write strobe
//   wdata_fifo  row to the FIFO (the hold register)
//   word_cnt    words accepted into the current row
//   row_pending hold register occupied
//   ovf         sticky, a completed row was dropped
module spi_row_packer #(
    parameter  int DWIDTH = 136,
    parameter  int WWIDTH = 16,
    localparam int NWORDS = (DWIDTH + WWIDTH - 1) / WWIDTH,
    localparam int REM    = DWIDTH - (NWORDS - 1) * WWIDTH,
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_en,
    input  logic [WWIDTH-1:0] wdata_spi,
    input  logic              sof,
    input  logic              clr_ovf,
    input  logic              full_fifo,
    output logic              wr_en_fifo,
    output logic [DWIDTH-1:0] wdata_fifo,
    output logic [CW-1:0]     word_cnt,
    output logic              row_pending,
    output logic              ovf
);

    // Only the first NWORDS-1 words are ever held in the assembly register;
    // the final word is merged straight into the completed row, so the
    // register is just wide enough for those leading words.
    localparam int AW = DWIDTH - REM;

    logic [AW-1:0]     asm_reg;
    logic [DWIDTH-1:0] hold;
    logic              last_word;
    logic              hold_accept;
    logic [DWIDTH-1:0] row;

    // A sof in the same cycle as a push restarts the row, so that word can
    // never be the final word of the old row.
    assign last_word   = push_en && !sof && (word_cnt == CW'(NWORDS - 1));
    assign row         = {asm_reg, wdata_spi[REM-1:0]};
    // The hold register can take a new row if it is empty, or if its
    // current contents leave for the FIFO in this same cycle.
    assign hold_accept = !row_pending || !full_fifo;

    assign wr_en_fifo  = row_pending && !full_fifo;
    assign wdata_fifo  = hold;

    // Word counter and assembly shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            asm_reg  <= '0;
        end else if (sof) begin
            if (push_en) begin
                asm_reg  <= {{(AW - WWIDTH){1'b0}}, wdata_spi};
                word_cnt <= CW'(1);
            end else begin
                asm_reg  <= '0;
                word_cnt <= '0;
            end
        end else if (push_en) begin
            if (last_word) begin
                asm_reg  <= '0;
                word_cnt <= '0;
            end else begin
                asm_reg  <= {asm_reg[AW-WWIDTH-1:0], wdata_spi};
                word_cnt <= word_cnt + CW'(1);
            end
        end
    end

    // Hold register and its occupancy flag. A newly arriving row keeps
    // row_pending set even when the previous row is written out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold        <= '0;
            row_pending <= 1'b0;
        end else if (last_word && hold_accept) begin
            hold        <= row;
            row_pending <= 1'b1;
        end else if (wr_en_fifo) begin
            row_pending <= 1'b0;
        end
    end

    // Sticky overflow; a drop in the same cycle wins over clr_ovf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_word && !hold_accept) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_row_packer.sv
// tb_spi_row_packer
// Directed testbench for spi_row_packer with hand-computed expected rows.
// Inputs change 1 time unit after the rising edge; FIFO writes are
// captured on the falling edge.
module tb_spi_row_packer;

    logic         clk;
    logic         rst_n;
    logic         push_en;
    logic [15:0]  wdata_spi;
    logic         sof;
    logic         clr_ovf;
    logic         full_fifo;
    logic         wr_en_fifo;
    logic [135:0] wdata_fifo;
    logic [3:0]   word_cnt;
    logic         row_pending;
    logic         ovf;

    int testCount = 0;
    int failCount = 0;
    int cycleCount = 0;
    int wrCount = 0;
    logic [135:0] lastData = '0;
    int wrCycles[$];
    logic [135:0] wrData[$];

    spi_row_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_en    (push_en),
        .wdata_spi  (wdata_spi),
        .sof        (sof),
        .clr_ovf    (clr_ovf),
        .full_fifo  (full_fifo),
        .wr_en_fifo (wr_en_fifo),
        .wdata_fifo (wdata_fifo),
        .word_cnt   (word_cnt),
        .row_pending(row_pending),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Record every FIFO write, away from the active edge.
    always @(negedge clk) begin
        if (wr_en_fifo === 1'b1) begin
            wrCount  = wrCount + 1;
            lastData = wdata_fifo;
            wrCycles.push_back(cycleCount);
            wrData.push_back(wdata_fifo);
        end
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] w);
        push_en   = 1'b1;
        wdata_spi = w;
        tick();
        push_en   = 1'b0;
    endtask

    task automatic pushRow(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) applyStimulus(base + 16'(i));
    endtask

    // Row built from words base..base+8; only the low byte of the ninth counts.
    function automatic logic [135:0] makeRow(input logic [15:0] base);
        logic [135:0] r;
        logic [15:0]  w;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            w = base + 16'(i);
            r = {r[119:0], w};
        end
        w = base + 16'd8;
        r = {r[127:0], w[7:0]};
        return r;
    endfunction

    int wrBefore;

    initial begin
        rst_n = 1'b0; push_en = 1'b0; wdata_spi = '0; sof = 1'b0;
        clr_ovf = 1'b0; full_fifo = 1'b0;
        tick();
        tick();
        checkOutput("reset word_cnt", 256'(word_cnt), 256'd0);
        checkOutput("reset row_pending", 256'(row_pending), 256'd0);
        checkOutput("reset ovf", 256'(ovf), 256'd0);
        checkOutput("reset wr_en", 256'(wr_en_fifo), 256'd0);
        checkOutput("reset wdata", 256'(wdata_fifo), 256'd0);
        // push_en while in reset must be ignored
        applyStimulus(16'hFFFF);
        checkOutput("push in reset", 256'(word_cnt), 256'd0);
        rst_n = 1'b1;
        tick();

        // Basic row
        wrBefore = wrCount;
        for (int i = 1; i <= 9; i++) applyStimulus(16'(i));
        checkOutput("basic wr_en", 256'(wr_en_fifo), 256'd1);
        checkOutput("basic data", 256'(wdata_fifo),
                    256'(136'h0001_0002_0003_0004_0005_0006_0007_0008_09));
        checkOutput("basic word_cnt", 256'(word_cnt), 256'd0);
        tick();
        checkOutput("basic pending fall", 256'(row_pending), 256'd0);
        checkOutput("basic wr_en fall", 256'(wr_en_fifo), 256'd0);
        checkOutput("basic one write", 256'(wrCount - wrBefore), 256'd1);

        // Back-to-back rows
        wrCycles.delete();
        wrData.delete();
        pushRow(16'h1000, 9);
        pushRow(16'h1010, 9);
        tick();
        checkOutput("b2b writes", 256'(wrData.size()), 256'd2);
        if (wrData.size() == 2) begin
            checkOutput("b2b row1", 256'(wrData[0]), 256'(makeRow(16'h1000)));
            checkOutput("b2b row2", 256'(wrData[1]), 256'(makeRow(16'h1010)));
            checkOutput("b2b spacing", 256'(wrCycles[1] - wrCycles[0]), 256'd9);
        end
        checkOutput("b2b ovf", 256'(ovf), 256'd0);

        // Backpressure
        full_fifo = 1'b1;
        wrBefore = wrCount;
        pushRow(16'h2000, 9);
        checkOutput("bp pending", 256'(row_pending), 256'd1);
        checkOutput("bp wr_en held", 256'(wr_en_fifo), 256'd0);
        pushRow(16'h3000, 5);
        checkOutput("bp word_cnt", 256'(word_cnt), 256'd5);
        full_fifo = 1'b0;
        #1;
        checkOutput("bp wr_en release", 256'(wr_en_fifo), 256'd1);
        checkOutput("bp data", 256'(wdata_fifo), 256'(makeRow(16'h2000)));
        tick();
        checkOutput("bp pending clear", 256'(row_pending), 256'd0);
        checkOutput("bp word_cnt kept", 256'(word_cnt), 256'd5);
        checkOutput("bp ovf", 256'(ovf), 256'd0);
        checkOutput("bp one write", 256'(wrCount - wrBefore), 256'd1);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        checkOutput("sof clears cnt", 256'(word_cnt), 256'd0);

        // Overflow
        full_fifo = 1'b1;
        pushRow(16'h4000, 9);
        pushRow(16'h4010, 9);
        checkOutput("ovf set", 256'(ovf), 256'd1);
        checkOutput("ovf hold kept", 256'(wdata_fifo), 256'(makeRow(16'h4000)));
        checkOutput("ovf pending", 256'(row_pending), 256'd1);
        pushRow(16'h4020, 8);
        clr_ovf = 1'b1;
        applyStimulus(16'h4028);
        clr_ovf = 1'b0;
        checkOutput("ovf set wins", 256'(ovf), 256'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checkOutput("ovf cleared", 256'(ovf), 256'd0);
        full_fifo = 1'b0;
        tick();
        checkOutput("ovf drain data", 256'(lastData), 256'(makeRow(16'h4000)));
        checkOutput("ovf drain pending", 256'(row_pending), 256'd0);

        // sof realign
        pushRow(16'h5000, 4);
        checkOutput("sof pre cnt", 256'(word_cnt), 256'd4);
        sof = 1'b1;
        applyStimulus(16'hA5A5);
        sof = 1'b0;
        checkOutput("sof+push cnt", 256'(word_cnt), 256'd1);
        pushRow(16'h6001, 8);
        checkOutput("sof wr_en", 256'(wr_en_fifo), 256'd1);
        checkOutput("sof msbs", 256'(wdata_fifo[135:120]), 256'h0A5A5);
        checkOutput("sof row", 256'(wdata_fifo),
                    256'(136'hA5A5_6001_6002_6003_6004_6005_6006_6007_08));
        tick();

        // Async reset mid-row, with a row held under backpressure
        full_fifo = 1'b1;
        pushRow(16'h7000, 9);
        pushRow(16'h7100, 5);
        rst_n = 1'b0;
        #1;
        checkOutput("arst word_cnt", 256'(word_cnt), 256'd0);
        checkOutput("arst pending", 256'(row_pending), 256'd0);
        checkOutput("arst wdata", 256'(wdata_fifo), 256'd0);
        checkOutput("arst wr_en", 256'(wr_en_fifo), 256'd0);
        checkOutput("arst ovf", 256'(ovf), 256'd0);
        full_fifo = 1'b0;
        #4;
        rst_n = 1'b1;
        tick();
        wrBefore = wrCount;
        tick();
        tick();
        checkOutput("arst no write", 256'(wrCount - wrBefore), 256'd0);
        pushRow(16'h8000, 9);
        tick();
        checkOutput("arst next row", 256'(lastData), 256'(makeRow(16'h8000)));
        checkOutput("arst next count", 256'(wrCount - wrBefore), 256'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/spi_row_packer.md
Name: spi_row_packer

Overview:
- Write-direction counterpart of the FIFO readout path.
- Accepts 16-bit words strobed in from the QSPI interface and assembles them MSB-first into DWIDTH-bit rows.
- Pushes each completed row into a sync_fifo write port (wr_en/wdata/full).
- Double-buffered: a completed row sits in a hold register while the next row assembles; overflow is flagged, never silently corrupted.

Parameters:
- DWIDTH, 136: row width written to the FIFO.
- WWIDTH, 16: SPI word width.
- NWORDS, ceil(DWIDTH/WWIDTH) = 9 (derived, localparam): words per row.
- REM, DWIDTH - (NWORDS-1)*WWIDTH = 8 (derived): valid low bits of the final word.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- push_en  in  1  one-cycle strobe: wdata_spi valid
- wdata_spi  in  WWIDTH  word from QSPI
- sof  in  1  start-of-frame: synchronously discard the partial row
- clr_ovf  in  1  clear the sticky overflow flag
- full_fifo  in  1  FIFO full flag
- wr_en_fifo  out  1  FIFO write strobe
- wdata_fifo  out  DWIDTH  row to the FIFO
- word_cnt  out  $clog2(NWORDS)  words accepted into the current row
- row_pending  out  1  hold register occupied
- ovf  out  1  sticky: a completed row was dropped

Behaviour:
- Reset (async, rst_n=0): word_cnt=0, assembly register=0, hold register=0, row_pending=0, ovf=0, wr_en_fifo=0, wdata_fifo=0.
- Assembly, on push_en with word_cnt < NWORDS-1:
  - asm <= {asm[DWIDTH-WWIDTH-1:0], wdata_spi}
  - word_cnt++
- Final word, on push_en with word_cnt == NWORDS-1:
  - row = {asm[DWIDTH-REM-1:0], wdata_spi[REM-1:0]}; wdata_spi[WWIDTH-1:REM] is ignored.
  - word_cnt <= 0.
- Completed-row transfer, evaluated in the same cycle as the final word:
  - If hold is free, or is being written this cycle: hold <= row, row_pending <= 1.
  - Otherwise (hold occupied and full_fifo=1): row dropped, ovf <= 1, hold unchanged.
- Write port:
  - wr_en_fifo = row_pending & ~full_fifo (combinational); wdata_fifo = hold.
  - On a write with no new row arriving in that cycle: row_pending <= 0.
  - Latency: final word accepted in cycle N → wr_en_fifo may assert in cycle N+1.
- Backpressure: while full_fifo=1, hold persists indefinitely and assembly of the next row continues. Up to NWORDS-1 further words are absorbed without loss.
- sof:
  - word_cnt <= 0 and asm <= 0; hold and row_pending are unaffected.
  - sof with push_en in the same cycle: the word becomes word 0 of the new row, so word_cnt=1 afterwards.
- ovf: set takes priority over clr_ovf in the same cycle; cleared only by clr_ovf or reset.
- push_en while rst_n=0: ignored.
- Reset mid-row: partial row and hold are lost; no wr_en_fifo pulse follows.
- word_cnt never exceeds NWORDS-1.

Test Plan:
- Basic row: after reset, push 16'h0001..16'h0009 on consecutive cycles, full_fifo=0 → exactly one wr_en_fifo pulse, one cycle after the 9th push. wdata_fifo = {16'h0001,16'h0002,...,16'h0008,8'h09}; row_pending falls the following cycle; word_cnt=0.
- Back-to-back rows: push 18 words continuously → two single-cycle wr_en_fifo pulses 9 cycles apart, with correct data each; ovf=0.
- Backpressure: full_fifo=1, push 9 words → row_pending=1, wr_en_fifo=0. Push 5 more (word_cnt=5), then drop full_fifo → one write of row 1, row_pending=0, word_cnt stays 5, ovf=0.
- Overflow: full_fifo held at 1, push 18 words → second row dropped, ovf=1, and hold still holds row 1. Then assert clr_ovf together with another completed row while still full → ovf stays 1. clr_ovf alone → ovf=0.
- sof realign: push 4 words, then sof together with push of 16'hA5A5 → word_cnt=1. Eight more pushes → row MSBs = 16'hA5A5.
- Async reset mid-row: push 5 words, pulse rst_n low for a half-cycle → all outputs 0 immediately. A subsequent 9-word row produces correct data.
